// File: rtl/event_group_rr_arbiter.sv
// Round-robin arbiter node for one level of the event-camera readout tree.
//
// Grants one child of a LVL_ROWS x LVL_COLS block at a time. The grant is held
// until the downstream readout acknowledges it, or until the child drops its
// request. After an acknowledged grant, the arbiter spends one cycle with no
// grant so the child can drop its request. It then arbitrates again.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      asynchronous active-high reset
//   en_i         parent enable; a new grant may start only while high
//   req_i[N]     child requests, bit index = row*LVL_COLS + col
//   ack_i        downstream consumed the current event
//   gnt_o[N]     registered one-hot grant
//   gnt_valid_o  registered, equals |gnt_o
//   row_add_o    registered row of granted child
//   col_add_o    registered column of granted child
//   active_o     combinational OR of req_i, forwarded to the parent level
module event_group_rr_arbiter #(
    parameter int unsigned LVL_ROWS = 2,
    parameter int unsigned LVL_COLS = 2,
    parameter int unsigned LVL_ADD  = 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic                         en_i,
    input  logic [LVL_ROWS*LVL_COLS-1:0] req_i,
    input  logic                         ack_i,
    output logic [LVL_ROWS*LVL_COLS-1:0] gnt_o,
    output logic                         gnt_valid_o,
    output logic [LVL_ADD-1:0]           row_add_o,
    output logic [LVL_ADD-1:0]           col_add_o,
    output logic                         active_o
);

    localparam int unsigned N  = LVL_ROWS * LVL_COLS;
    localparam int unsigned PW = 2 * LVL_ADD;

    typedef enum logic [1:0] {StIdle, StGrant, StRelease} state_t;

    state_t             r_state, w_state_d;
    logic [PW-1:0]      r_ptr, w_ptr_d;
    logic [PW-1:0]      r_win, w_win_d;
    logic [N-1:0]       r_gnt, w_gnt_d;
    logic               r_valid, w_valid_d;
    logic [LVL_ADD-1:0] r_row, w_row_d;
    logic [LVL_ADD-1:0] r_col, w_col_d;

    logic               w_found;
    logic [PW-1:0]      w_pick;
    logic [PW-1:0]      w_idx;

    assign active_o = |req_i;

    // Search from the highest offset down, so the lowest offset from r_ptr wins.
    // N is a power of two, so the index wraps by truncation.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            w_idx = r_ptr + PW'(i);
            if (req_i[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_ptr_d   = r_ptr;
        w_win_d   = r_win;
        w_gnt_d   = r_gnt;
        w_valid_d = r_valid;
        w_row_d   = r_row;
        w_col_d   = r_col;
        unique case (r_state)
            StIdle: begin
                if (en_i && w_found) begin
                    w_win_d          = w_pick;
                    w_gnt_d          = '0;
                    w_gnt_d[w_pick]  = 1'b1;
                    w_valid_d        = 1'b1;
                    w_row_d          = w_pick[PW-1:LVL_ADD];
                    w_col_d          = w_pick[LVL_ADD-1:0];
                    w_state_d        = StGrant;
                end
            end
            StGrant: begin
                // Acknowledge takes priority over a simultaneous withdrawal.
                if (ack_i) begin
                    w_ptr_d   = r_win + PW'(1);
                    w_gnt_d   = '0;
                    w_valid_d = 1'b0;
                    w_state_d = StRelease;
                end else if (!req_i[r_win]) begin
                    w_gnt_d   = '0;
                    w_valid_d = 1'b0;
                    w_state_d = StIdle;
                end
            end
            StRelease: begin
                w_state_d = StIdle;
            end
            default: begin
                w_gnt_d   = '0;
                w_valid_d = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= StIdle;
            r_ptr   <= '0;
            r_win   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_row   <= '0;
            r_col   <= '0;
        end else begin
            r_state <= w_state_d;
            r_ptr   <= w_ptr_d;
            r_win   <= w_win_d;
            r_gnt   <= w_gnt_d;
            r_valid <= w_valid_d;
            r_row   <= w_row_d;
            r_col   <= w_col_d;
        end
    end

    assign gnt_o       = r_gnt;
    assign gnt_valid_o = r_valid;
    assign row_add_o   = r_row;
    assign col_add_o   = r_col;

endmodule

// File: tb/tb_event_group_rr_arbiter.sv
// Bench for event_group_rr_arbiter (2x2 block). The bench compares the DUT with a
// transaction-level model. Each cycle, the model tracks the current owner, the
// rotating start point and a release cycle.
module tb_event_group_rr_arbiter;

    localparam int N = 4;

    logic         clk_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         en_i = 1'b0;
    logic [N-1:0] req_i = '0;
    logic         ack_i = 1'b0;
    logic [N-1:0] gnt_o;
    logic         gnt_valid_o;
    logic [0:0]   row_add_o;
    logic [0:0]   col_add_o;
    logic         active_o;

    event_group_rr_arbiter #(
        .LVL_ROWS(2),
        .LVL_COLS(2),
        .LVL_ADD (1)
    ) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .en_i       (en_i),
        .req_i      (req_i),
        .ack_i      (ack_i),
        .gnt_o      (gnt_o),
        .gnt_valid_o(gnt_valid_o),
        .row_add_o  (row_add_o),
        .col_add_o  (col_add_o),
        .active_o   (active_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int m_owner = -1;  // granted child index, -1 when no grant
    int m_ptr   = 0;   // child index where the next search starts
    bit m_rel   = 1'b0;
    int m_row   = 0;
    int m_col   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] r);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_rel   = 1'b0;
        m_row   = 0;
        m_col   = 0;
    endtask

    task automatic model_step();
        int w;
        if (m_rel) begin
            m_rel = 1'b0;
        end else if (m_owner < 0) begin
            w = pick(m_ptr, req_i);
            if (en_i && w >= 0) begin
                m_owner = w;
                m_row   = w / 2;
                m_col   = w % 2;
            end
        end else if (ack_i) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
            m_rel   = 1'b1;
        end else if (!req_i[m_owner]) begin
            m_owner = -1;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] eg;
        eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
        chk({tag, ".gnt"}, 32'(gnt_o), eg);
        chk({tag, ".valid"}, 32'(gnt_valid_o), (m_owner >= 0) ? 32'd1 : 32'd0);
        chk({tag, ".row"}, 32'(row_add_o), 32'(m_row));
        chk({tag, ".col"}, 32'(col_add_o), 32'(m_col));
    endtask

    // Drive one cycle of inputs, check active_o, step the model, and check outputs.
    task automatic cyc(input string tag, input logic e, input logic [N-1:0] r, input logic a);
        en_i  = e;
        req_i = r;
        ack_i = a;
        #1;
        chk({tag, ".active"}, 32'(active_o), 32'(|r));
        @(posedge clk_i);
        model_step();
        #1;
        check_outputs(tag);
    endtask

    // Assert reset between edges and expect the grant to drop before the next edge.
    task automatic pulse_reset_mid(input string tag);
        #2;
        reset_i = 1'b1;
        #1;
        model_reset();
        check_outputs({tag, ".async"});
        @(posedge clk_i);
        #1;
        check_outputs({tag, ".held"});
        reset_i = 1'b0;
    endtask

    logic [N-1:0] order[$];
    logic [N-1:0] exp_order[5];

    initial begin
        // Power-up reset
        reset_i = 1'b1;
        #2;
        model_reset();
        check_outputs("reset");
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        check_outputs("reset_rel");

        // Single request from child 2 (row 1, col 0)
        cyc("single0", 1'b1, 4'b0100, 1'b0);
        chk("single_gnt", 32'(gnt_o), 32'h4);
        chk("single_row", 32'(row_add_o), 32'd1);
        chk("single_col", 32'(col_add_o), 32'd0);
        cyc("single1", 1'b1, 4'b0100, 1'b0);
        cyc("single2", 1'b1, 4'b0100, 1'b0);
        cyc("single3", 1'b1, 4'b0100, 1'b1);
        chk("single_clr", 32'(gnt_o), 32'h0);
        cyc("single4", 1'b1, 4'b0000, 1'b0);

        // Fairness from a fresh start point
        pulse_reset_mid("rst_idle");
        for (int i = 0; i < 30 && order.size() < 5; i++) begin
            cyc("fair", 1'b1, 4'b1111, (m_owner >= 0));
            if (gnt_valid_o) order.push_back(gnt_o);
        end
        exp_order[0] = 4'b0001;
        exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100;
        exp_order[3] = 4'b1000;
        exp_order[4] = 4'b0001;
        chk("fair_count", 32'(order.size()), 32'd5);
        for (int i = 0; i < 5 && i < order.size(); i++) begin
            chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(exp_order[i]));
        end
        cyc("fair_end0", 1'b1, 4'b0000, 1'b1);
        cyc("fair_end1", 1'b1, 4'b0000, 1'b0);

        // Wrap: serve 1 then 2, so that the search starts at 3
        cyc("wrap_a", 1'b1, 4'b0010, 1'b0);
        cyc("wrap_b", 1'b1, 4'b0010, 1'b1);
        cyc("wrap_c", 1'b1, 4'b0000, 1'b0);
        cyc("wrap_d", 1'b1, 4'b0100, 1'b0);
        cyc("wrap_e", 1'b1, 4'b0100, 1'b1);
        cyc("wrap_rel", 1'b1, 4'b0011, 1'b0);
        cyc("wrap_g0", 1'b1, 4'b0011, 1'b0);
        chk("wrap_idx0", 32'(gnt_o), 32'h1);
        cyc("wrap_f", 1'b1, 4'b0011, 1'b1);
        cyc("wrap_g", 1'b1, 4'b0011, 1'b0);
        cyc("wrap_g1", 1'b1, 4'b0011, 1'b0);
        chk("wrap_idx1", 32'(gnt_o), 32'h2);
        cyc("wrap_h", 1'b1, 4'b0011, 1'b1);
        cyc("wrap_i", 1'b1, 4'b0000, 1'b0);

        // Enable gating
        for (int i = 0; i < 3; i++) cyc("en_low", 1'b0, 4'b0010, 1'b0);
        chk("en_low_gnt", 32'(gnt_o), 32'h0);
        cyc("en_rise", 1'b1, 4'b0010, 1'b0);
        chk("en_rise_gnt", 32'(gnt_o), 32'h2);
        cyc("en_drop0", 1'b0, 4'b0010, 1'b0);
        cyc("en_drop1", 1'b0, 4'b0010, 1'b0);
        chk("en_drop_hold", 32'(gnt_o), 32'h2);
        cyc("en_ack", 1'b0, 4'b0010, 1'b1);
        chk("en_ack_clr", 32'(gnt_o), 32'h0);
        cyc("en_idle", 1'b0, 4'b0000, 1'b0);

        // Withdrawal, then withdrawal together with an acknowledge
        cyc("wd_g2", 1'b1, 4'b0100, 1'b0);
        cyc("wd_drop", 1'b1, 4'b0000, 1'b0);
        chk("wd_clr", 32'(gnt_o), 32'h0);
        cyc("wd_again", 1'b1, 4'b0111, 1'b0);
        chk("wd_same_idx", 32'(gnt_o), 32'h4);
        cyc("wd_ack", 1'b1, 4'b0000, 1'b1);
        cyc("wd_rel", 1'b1, 4'b1001, 1'b0);
        cyc("wd_g3", 1'b1, 4'b1001, 1'b0);
        chk("wd_ptr_adv", 32'(gnt_o), 32'h8);
        cyc("wd_hold", 1'b1, 4'b1000, 1'b0);

        // Reset while a grant is held
        pulse_reset_mid("rst_grant");
        cyc("rst_after", 1'b1, 4'b1001, 1'b0);
        chk("rst_ptr0", 32'(gnt_o), 32'h1);
        cyc("rst_ack", 1'b1, 4'b1001, 1'b1);
        cyc("rst_idle", 1'b1, 4'b0000, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rand", ($urandom_range(3, 0) != 0), N'($urandom), $urandom_range(1, 0) == 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
